// File: rtl/barrido_pkg.sv
// ---------------------------------------------------------------------------
// barrido_pkg
// Shared types and constants for the exhaustive input-vector sequencer.
//   state_t    : sequencer states IDLE / RUN / FIN
//   SIG_W      : width of the response signature
//   MISR_TAPS  : feedback taps of the signature register (bits 15,13,12,10)
//   bin2gray   : binary to reflected-Gray conversion, 16 bits wide
// ---------------------------------------------------------------------------
package barrido_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam int SIG_W = 16;

   localparam logic [SIG_W-1:0] MISR_TAPS = 16'hB400;

   // Adjacent Gray codes differ in one bit, so the unit under test sees
   // exactly one input toggle per step in Gray mode.
   function automatic logic [SIG_W-1:0] bin2gray(input logic [SIG_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/barrido_entradas_misr16.sv
// ---------------------------------------------------------------------------
// misr16
// 16-bit multiple-input signature register used to compact the sampled
// responses of a sweep into one word.
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset, clears q
//   clr  in   clears q (a new sweep is starting)
//   en   in   shift in din on this edge
//   din  in   16-bit response word
//   q    out  current signature
// ---------------------------------------------------------------------------
module misr16
   import barrido_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [SIG_W-1:0]  din,
   output logic [SIG_W-1:0]  q
);

   // Shift left, feed the XOR of the tapped bits into bit 0, then fold in
   // the new response. Clearing wins over shifting because a new sweep
   // must always start from a zero signature.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= {q[SIG_W-2:0], ^(q & MISR_TAPS)} ^ din;
      end
   end

endmodule

// File: rtl/barrido_entradas.sv
// ---------------------------------------------------------------------------
// barrido_entradas
// Exhaustive input-vector sequencer. On start it walks all 2^N_IN input
// combinations in binary or Gray order, holds each vector for d_lat cycles
// and flags the last hold cycle with sample. A one-cycle done pulse follows
// a completed (non-looping) sweep.
//
// Build option: define BARRIDO_SIG_EN to compact the sampled responses into
// a 16-bit MISR signature on sig; otherwise sig is tied to 0.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   begin a sweep (only honoured in IDLE)
//   abort    in   end a sweep immediately, no done
//   mode     in   0 = binary order, 1 = Gray order (latched at start)
//   loop_en  in   wrap to index 0 after the last vector (live)
//   dwell    in   cycles per vector, 0 behaves as 1 (latched at start)
//   resp     in   response of the unit under test
//   vec      out  current stimulus vector (registered)
//   busy     out  high while sweeping
//   sample   out  high on the last hold cycle of each vector
//   done     out  one-cycle pulse after a completed sweep
//   sig      out  response signature
// ---------------------------------------------------------------------------
module barrido_entradas
   import barrido_pkg::*;
#(
   parameter int N_IN    = 3,
   parameter int N_OUT   = 2,
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic               mode,
   input  logic               loop_en,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [N_OUT-1:0]   resp,
   output logic [N_IN-1:0]    vec,
   output logic               busy,
   output logic               sample,
   output logic               done,
   output logic [SIG_W-1:0]   sig
);

   state_t               state_q, state_d;
   logic [N_IN-1:0]      idx_q, idx_d;
   logic [DWELL_W-1:0]   hold_q, hold_d;
   logic [DWELL_W-1:0]   d_lat_q, d_lat_d;
   logic                 m_lat_q, m_lat_d;
   logic [N_IN-1:0]      vec_q, vec_d;
   logic [N_IN-1:0]      idx_inc;
   logic                 at_last_hold;
   logic                 start_ok;

   assign idx_inc      = idx_q + N_IN'(1);
   assign at_last_hold = (state_q == RUN) && (hold_q == d_lat_q - DWELL_W'(1));
   assign start_ok     = (state_q == IDLE) && start && !abort;

   // State register: every piece of sequencer state moves together on the
   // clock edge. d_lat resets to 1 so the hold compare is never against -1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         hold_q  <= '0;
         d_lat_q <= DWELL_W'(1);
         m_lat_q <= 1'b0;
         vec_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         d_lat_q <= d_lat_d;
         m_lat_q <= m_lat_d;
         vec_q   <= vec_d;
      end
   end

   // Next-state logic. vec is computed here from the index it will hold
   // next, so the registered vector is valid from the first RUN cycle.
   // Abort is applied last so it overrides any step taken above it.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      d_lat_d = d_lat_q;
      m_lat_d = m_lat_q;
      vec_d   = vec_q;
      case (state_q)
         IDLE: begin
            vec_d = '0;
            if (start_ok) begin
               state_d = RUN;
               idx_d   = '0;
               hold_d  = '0;
               d_lat_d = (dwell == '0) ? DWELL_W'(1) : dwell;
               m_lat_d = mode;
            end
         end
         RUN: begin
            if (at_last_hold) begin
               hold_d = '0;
               idx_d  = idx_inc;
               if ((idx_q == {N_IN{1'b1}}) && !loop_en) begin
                  state_d = FIN;
                  vec_d   = '0;
               end else if (m_lat_q) begin
                  vec_d = N_IN'(bin2gray(SIG_W'(idx_inc)));
               end else begin
                  vec_d = idx_inc;
               end
            end else begin
               hold_d = hold_q + DWELL_W'(1);
            end
         end
         FIN: begin
            state_d = IDLE;
            vec_d   = '0;
         end
         default: begin
            state_d = IDLE;
            vec_d   = '0;
         end
      endcase
      if (abort) begin
         state_d = IDLE;
         idx_d   = '0;
         hold_d  = '0;
         vec_d   = '0;
      end
   end

   // Output decode: status flags come straight from the current state so
   // they are all low in IDLE without extra gating.
   always_comb begin
      vec    = vec_q;
      busy   = 1'b0;
      sample = 1'b0;
      done   = 1'b0;
      case (state_q)
         RUN: begin
            busy   = 1'b1;
            sample = at_last_hold;
         end
         FIN: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

`ifdef BARRIDO_SIG_EN
   // A sample edge that coincides with abort is not folded in, since abort
   // cancels whatever the sweep was about to do on that edge.
   misr16 u_misr (
      .clk (clk),
      .rst (rst),
      .clr (start_ok),
      .en  (at_last_hold && !abort),
      .din (SIG_W'(resp)),
      .q   (sig)
   );
`else
   logic unused_resp;
   assign unused_resp = ^resp;
   assign sig = '0;
`endif

endmodule

// File: tb/tb_barrido_entradas.sv
module tb_barrido_entradas;

   localparam int N_IN    = 3;
   localparam int N_OUT   = 2;
   localparam int DWELL_W = 8;
   localparam int N_VEC   = 1 << N_IN;

   localparam logic [2:0] VEC_BIN [16] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3,
                                           3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7};
   localparam logic [2:0] VEC_GRAY [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               abort;
   logic               mode;
   logic               loop_en;
   logic [DWELL_W-1:0] dwell;
   logic [N_OUT-1:0]   resp;
   logic [N_IN-1:0]    vec;
   logic               busy;
   logic               sample;
   logic               done;
   logic [15:0]        sig;

   int  tests = 0;
   int  fails = 0;
   bit  check_en = 1'b0;

   // Behavioural model: phase 0 idle, 1 running, 2 finishing; m_t counts
   // RUN cycles within the current pass.
   int          m_phase = 0;
   int          m_t     = 0;
   int          m_d     = 1;
   bit          m_m     = 1'b0;
   logic [15:0] m_sig   = 16'h0000;

   logic [2:0]  vlog [1:40];
   logic [39:0] smask;
   logic [39:0] bmask;
   logic [39:0] dmask;

   always #5 clk = ~clk;

   barrido_entradas #(
      .N_IN    (N_IN),
      .N_OUT   (N_OUT),
      .DWELL_W (DWELL_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .abort   (abort),
      .mode    (mode),
      .loop_en (loop_en),
      .dwell   (dwell),
      .resp    (resp),
      .vec     (vec),
      .busy    (busy),
      .sample  (sample),
      .done    (done),
      .sig     (sig)
   );

   function automatic bit modelSample();
      return (m_phase == 1) && ((m_t % m_d) == (m_d - 1));
   endfunction

   function automatic logic [2:0] modelVec();
      int i;
      if (m_phase != 1) return 3'd0;
      i = m_t / m_d;
      if (m_m) i = i ^ (i >> 1);
      return 3'(i);
   endfunction

   // Model advances on each rising edge from the inputs present before it.
   always @(posedge clk) begin : model
      bit smp;
      smp = modelSample();
      if (rst) begin
         m_phase = 0;
         m_t     = 0;
         m_sig   = 16'h0000;
      end else if (abort) begin
         m_phase = 0;
      end else begin
         case (m_phase)
            0: begin
               if (start) begin
                  m_phase = 1;
                  m_t     = 0;
                  m_d     = (dwell == 0) ? 1 : int'(dwell);
                  m_m     = mode;
                  m_sig   = 16'h0000;
               end
            end
            1: begin
`ifdef BARRIDO_SIG_EN
               if (smp)
                  m_sig = {m_sig[14:0], m_sig[15] ^ m_sig[13] ^ m_sig[12] ^ m_sig[10]} ^ 16'(resp);
`endif
               m_t++;
               if (m_t == N_VEC * m_d) begin
                  if (loop_en) m_t = 0;
                  else m_phase = 2;
               end
            end
            default: m_phase = 0;
         endcase
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("model_vec", 32'(vec), 32'(modelVec()));
         checkOutput("model_busy", 32'(busy), 32'(m_phase == 1));
         checkOutput("model_sample", 32'(sample), 32'(modelSample()));
         checkOutput("model_done", 32'(done), 32'(m_phase == 2));
         checkOutput("model_sig", 32'(sig), 32'(m_sig));
      end
   end

   task automatic applyStimulus(input bit st, input bit ab, input bit md, input bit le,
                                input logic [DWELL_W-1:0] dw, input logic [N_OUT-1:0] rs);
      start   = st;
      abort   = ab;
      mode    = md;
      loop_en = le;
      dwell   = dw;
      resp    = rs;
   endtask

   // Start a sweep in cycle 0 and log outputs for cycles 1..ncyc.
   task automatic runDirected(input bit md, input bit le, input logic [DWELL_W-1:0] dw,
                              input logic [N_OUT-1:0] rs, input int ncyc, input int abort_at,
                              input int start_at, input int dw_chg_at, input int le_off_at);
      smask = '0;
      bmask = '0;
      dmask = '0;
      applyStimulus(1'b1, 1'b0, md, le, dw, rs);
      @(posedge clk); #1;
      for (int c = 1; c <= ncyc; c++) begin
         applyStimulus(c == start_at, c == abort_at, md, le && (c < le_off_at),
                       (c >= dw_chg_at) ? 8'd5 : dw, rs);
         @(negedge clk);
         vlog[c]    = vec;
         smask[c-1] = sample;
         bmask[c-1] = busy;
         dmask[c-1] = done;
         @(posedge clk); #1;
      end
      applyStimulus(1'b0, 1'b0, md, 1'b0, dw, rs);
   endtask

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   initial begin : main
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_en = 1'b1;

      // Reset values
      @(negedge clk);
      checkOutput("rst_vec", 32'(vec), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_sig", 32'(sig), 32'd0);
      @(posedge clk); #1;

      // Binary, dwell 2: vec 0,0,1,1..7,7 on cycles 1-16, done on 17
      runDirected(1'b0, 1'b0, 8'd2, 2'd1, 17, 0, 0, 99, 99);
      for (int c = 1; c <= 16; c++) checkOutput("bin_vec", 32'(vlog[c]), 32'(VEC_BIN[c-1]));
      checkOutput("bin_sample", 32'(smask[16:0]), 32'h0AAAA);
      checkOutput("bin_busy", 32'(bmask[16:0]), 32'h0FFFF);
      checkOutput("bin_done", 32'(dmask[16:0]), 32'h10000);

      // Gray, dwell 1, resp held at 1: done on cycle 9, signature 00FF
      runDirected(1'b1, 1'b0, 8'd1, 2'd1, 9, 0, 0, 99, 99);
      for (int c = 1; c <= 8; c++) checkOutput("gray_vec", 32'(vlog[c]), 32'(VEC_GRAY[c-1]));
      checkOutput("gray_done", 32'(dmask[8:0]), 32'h100);
      @(negedge clk);
`ifdef BARRIDO_SIG_EN
      checkOutput("sig_resp1", 32'(sig), 32'h00FF);
`else
      checkOutput("sig_resp1", 32'(sig), 32'h0000);
`endif
      @(posedge clk); #1;

      // dwell 0 behaves as 1; dwell change mid-sweep and start pulses ignored
      runDirected(1'b0, 1'b0, 8'd0, 2'd0, 9, 0, 4, 3, 99);
      checkOutput("dw0_busy", 32'(bmask[8:0]), 32'h0FF);
      checkOutput("dw0_done", 32'(dmask[8:0]), 32'h100);
      checkOutput("dw0_vec7", 32'(vlog[8]), 32'd7);
      @(negedge clk);
      checkOutput("sig_resp0", 32'(sig), 32'h0000);
      @(posedge clk); #1;

      // Looping: wrap with no gap, drop loop_en in second pass
      runDirected(1'b0, 1'b1, 8'd1, 2'd2, 20, 0, 0, 99, 12);
      checkOutput("loop_last", 32'(vlog[8]), 32'd7);
      checkOutput("loop_wrap", 32'(vlog[9]), 32'd0);
      checkOutput("loop_busy", 32'(bmask[19:0]), 32'h0FFFF);
      checkOutput("loop_done", 32'(dmask[19:0]), 32'h10000);

      // Abort during cycle 5: idle on cycle 6, never done
      runDirected(1'b0, 1'b0, 8'd2, 2'd3, 9, 5, 3, 99, 99);
      checkOutput("abort_busy", 32'(bmask[8:0]), 32'h01F);
      checkOutput("abort_done", 32'(dmask[8:0]), 32'h000);
      checkOutput("abort_vec", 32'(vlog[6]), 32'd0);

      // Reset mid-sweep
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1);
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_vec", 32'(vec), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_sig", 32'(sig), 32'd0);
      @(posedge clk); #1;

      // Randomized traffic, model checks every cycle
      for (int n = 0; n < 3000; n++) begin
         applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 79) == 0,
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 39) == 0) ? !loop_en : loop_en,
                       8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         rst = ($urandom_range(0, 299) == 0);
         @(posedge clk); #1;
      end
      rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 2'd0);
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 2'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
